// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures bytes strobed by the UART receiver and
// presents them first-word-fall-through on a valid/ready port with overflow status.
module uart_rx_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_LVL  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid,
  input  logic [DATA_WIDTH-1:0]   P_Data,
  input  logic                    out_ready,
  input  logic                    ovf_clr,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  output logic [7:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            ovf_count_q, ovf_count_d;

  logic push, pop, is_full, push_ok, drop;

  assign push    = data_valid;
  assign is_full = (count_q == DEPTH_C);
  assign pop     = out_valid & out_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push & (~is_full | pop);
  assign drop    = push & is_full & ~pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clearing takes priority over a drop landing in the same cycle.
    if (ovf_clr) begin
      overflow_d  = 1'b0;
      ovf_count_d = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= P_Data;
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign full        = is_full;
  assign almost_full = (count_q >= AFULL_C);
  assign overflow    = overflow_q;
  assign ovf_count   = ovf_count_q;

endmodule
